mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core; it sits in the E stage beside the ALU.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and provides MFHI/MFLO read data.
- Issues a stall request to the hazard logic while an operation is in flight.
- Latencies and data width are parametrised; the result is committed atomically at the end of the count, and an in-flight operation can be killed by reset.

---
 rtl/mdu_unit_if.sv | 31 +++
 rtl/mdu_unit.sv | 159 +++++++++++++++
 tb/tb_mdu_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_unit_if.sv
// Bus between the E-stage control and the multiply/divide unit.
//   mdu_op    : operation code (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO)
//   cancel    : E-stage instruction is being flushed; blocks state changes
//   A, B      : rs / rt operands
//   busy      : multiply/divide in flight
//   stall_req : hold the D stage (busy, or any MDU op being presented)
//   hi, lo    : architectural HI/LO registers
//   rd        : MFHI/MFLO read data, zero for any other op
interface mdu_unit_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        mdu_op;
  logic              cancel;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              busy;
  logic              stall_req;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] rd;

  modport master (
    output mdu_op, cancel, A, B,
    input  busy, stall_req, hi, lo, rd
  );

  modport slave (
    input  mdu_op, cancel, A, B,
    output busy, stall_req, hi, lo, rd
  );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// The result is computed when the operation starts, held in hi_n/lo_n and
// committed to HI/LO atomically when the busy count expires.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; kills any in-flight operation
//   bus   : mdu_unit_if slave (op/cancel/operands in; busy/stall/HI/LO/rd out)
module mdu_unit #(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } op_t;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi_r, lo_r, hi_n, lo_n;
  logic              div0;

  logic is_mul, is_div, op_valid, start, commit;

  assign is_mul   = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU);
  assign is_div   = (bus.mdu_op == OP_DIV)  || (bus.mdu_op == OP_DIVU);
  assign op_valid = (bus.mdu_op != OP_NONE) && (bus.mdu_op <= OP_MFLO);
  assign start    = (state == S_IDLE) && (is_mul || is_div) && !bus.cancel;
  assign commit   = (state == S_RUN) && (cnt == '0);

  // ---------------------------------------------------------------------
  // Arithmetic, evaluated on the operands present at the start edge
  // ---------------------------------------------------------------------
  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;

  assign prod_s = $signed({{DATA_W{bus.A[DATA_W-1]}}, bus.A})
                * $signed({{DATA_W{bus.B[DATA_W-1]}}, bus.B});
  assign prod_u = {{DATA_W{1'b0}}, bus.A} * {{DATA_W{1'b0}}, bus.B};

  // Signed divide is done on magnitudes so the most-negative / -1 case
  // falls out naturally: |A| = 2^(W-1), quotient negated wraps back to A,
  // remainder 0. A zero divisor is replaced by 1 only to keep the divider
  // well defined; that result is never committed.
  logic              neg_a, neg_b, b_zero;
  logic [DATA_W-1:0] mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;

  assign neg_a   = (bus.mdu_op == OP_DIV) && bus.A[DATA_W-1];
  assign neg_b   = (bus.mdu_op == OP_DIV) && bus.B[DATA_W-1];
  assign b_zero  = (bus.B == '0);
  assign mag_a   = neg_a ? -bus.A : bus.A;
  assign mag_b   = neg_b ? -bus.B : bus.B;
  assign divisor = b_zero ? DATA_W'(1) : mag_b;
  assign q_mag   = mag_a / divisor;
  assign r_mag   = mag_a % divisor;
  assign quot    = (neg_a ^ neg_b) ? -q_mag : q_mag;
  assign rem     = neg_a ? -r_mag : r_mag;

  logic [DATA_W-1:0] hi_calc, lo_calc;

  // NOTE: every variable driven here gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    hi_calc = '0;
    lo_calc = '0;
    case (bus.mdu_op)
      OP_MULT:         {hi_calc, lo_calc} = prod_s;
      OP_MULTU:        {hi_calc, lo_calc} = prod_u;
      OP_DIV, OP_DIVU: begin
        hi_calc = rem;
        lo_calc = quot;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start)     state_nx = S_RUN;
      S_RUN:  if (cnt == '0) state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  // NOTE: hi_n/lo_n/div0 are reset as well as HI/LO so a killed operation
  // leaves no stale pending result behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      hi_r <= '0;
      lo_r <= '0;
      hi_n <= '0;
      lo_n <= '0;
      div0 <= 1'b0;
    end else begin
      if (start) begin
        cnt  <= is_mul ? MULT_LOAD : DIV_LOAD;
        hi_n <= hi_calc;
        lo_n <= lo_calc;
        div0 <= is_div && b_zero;
      end else if ((state == S_RUN) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      // Divide by zero runs the full count but leaves HI/LO untouched.
      if (commit && !div0) begin
        hi_r <= hi_n;
        lo_r <= lo_n;
      end

      if ((state == S_IDLE) && !bus.cancel) begin
        if (bus.mdu_op == OP_MTHI) hi_r <= bus.A;
        if (bus.mdu_op == OP_MTLO) lo_r <= bus.A;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.busy      = (state == S_RUN);
  assign bus.stall_req = bus.busy || (op_valid && !bus.cancel);
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
  assign bus.rd        = (bus.mdu_op == OP_MFHI) ? hi_r :
                         (bus.mdu_op == OP_MFLO) ? lo_r : '0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: a default-latency instance (m)
// and a single-cycle-latency instance (f). Inputs change on the falling
// edge and outputs are sampled on the falling edge.
module tb_mdu_unit;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MFHI  = 4'd7;
  localparam logic [3:0] MFLO  = 4'd8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_unit_if #(.DATA_W(32)) m ();
  mdu_unit_if #(.DATA_W(32)) f ();

  mdu_unit #(.DATA_W(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m.slave)
  );

  mdu_unit #(.DATA_W(32), .MULT_CYCLES(1), .DIV_CYCLES(1), .CNT_W(1)) u_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (f.slave)
  );

  // The pipeline must never present a state-changing op while busy.
  always @(posedge clk) begin
    if (!reset && m.busy && !m.cancel && m.mdu_op >= MULT && m.mdu_op <= MTLO) begin
      errors++;
      $display("FAIL op_while_busy: op %0d presented, required none", m.mdu_op);
    end
    if (!reset && f.busy && !f.cancel && f.mdu_op >= MULT && f.mdu_op <= MTLO) begin
      errors++;
      $display("FAIL op_while_busy_fast: op %0d presented, required none", f.mdu_op);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // Called on a falling edge: presents op for one cycle, then counts the
  // falling edges on which busy is seen high. Returns on the first falling
  // edge with busy low (cycles = -1 if the bound expires).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles, output logic stall);
    m.mdu_op = op;
    m.A      = a;
    m.B      = b;
    #1;
    stall = m.stall_req;
    @(negedge clk);
    m.mdu_op = NONE;
    cycles   = 0;
    while (m.busy === 1'b1 && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 50) cycles = -1;
  endtask

  task automatic test_reset();
    m.mdu_op = NONE; m.cancel = 1'b0; m.A = '0; m.B = '0;
    f.mdu_op = NONE; f.cancel = 1'b0; f.A = '0; f.B = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", m.busy); end
    checks++; if (m.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", m.hi); end
    checks++; if (m.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", m.lo); end
    checks++; if (m.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", m.stall_req); end
    checks++; if (m.rd !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", m.rd); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int cyc; logic st;
    run_op(MULT, 32'hFFFF_FFFD, 32'd5, cyc, st);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_stall: got %b want 1", st); end
    checks++; if (cyc != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", cyc); end
    checks++; if (m.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", m.hi); end
    checks++; if (m.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", m.lo); end
  endtask

  task automatic test_div();
    int cyc; logic st;
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, cyc, st);
    checks++; if (cyc != 10) begin errors++; $display("FAIL div_busy_cycles: got %0d want 10", cyc); end
    checks++; if (m.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", m.lo); end
    checks++; if (m.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", m.hi); end
    run_op(DIVU, 32'd7, 32'd2, cyc, st);
    checks++; if (m.lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h want 3", m.lo); end
    checks++; if (m.hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h want 1", m.hi); end
    // 7 / -2 = -3 remainder 1 (remainder follows the dividend)
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, cyc, st);
    checks++; if (m.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo: got %h want fffffffd", m.lo); end
    checks++; if (m.hi !== 32'd1) begin errors++; $display("FAIL div_negb_hi: got %h want 1", m.hi); end
  endtask

  task automatic test_move();
    int cyc; logic st;
    run_op(MTLO, 32'h0, 32'h0, cyc, st);
    run_op(MTHI, 32'h1234_5678, 32'h0, cyc, st);
    checks++; if (cyc != 0) begin errors++; $display("FAIL mthi_busy: got %0d busy cycles want 0", cyc); end
    checks++; if (m.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", m.hi); end
    checks++; if (m.lo !== 32'h0) begin errors++; $display("FAIL mtlo_lo: got %h want 0", m.lo); end
    m.mdu_op = MFLO; #1;
    checks++; if (m.rd !== 32'h0) begin errors++; $display("FAIL mflo_rd: got %h want 0", m.rd); end
    checks++; if (m.stall_req !== 1'b1) begin errors++; $display("FAIL mflo_stall: got %b want 1", m.stall_req); end
    m.mdu_op = MFHI; #1;
    checks++; if (m.rd !== 32'h1234_5678) begin errors++; $display("FAIL mfhi_rd: got %h want 12345678", m.rd); end
    m.mdu_op = NONE; #1;
    checks++; if (m.rd !== 32'h0) begin errors++; $display("FAIL none_rd: got %h want 0", m.rd); end
    @(negedge clk);
  endtask

  task automatic test_div_corner();
    int cyc; logic st;
    run_op(MTHI, 32'hAA, 32'h0, cyc, st);
    run_op(MTLO, 32'hBB, 32'h0, cyc, st);
    run_op(DIV, 32'h1234, 32'h0, cyc, st);
    checks++; if (cyc != 10) begin errors++; $display("FAIL div0_busy_cycles: got %0d want 10", cyc); end
    checks++; if (m.hi !== 32'hAA) begin errors++; $display("FAIL div0_hi: got %h want aa", m.hi); end
    checks++; if (m.lo !== 32'hBB) begin errors++; $display("FAIL div0_lo: got %h want bb", m.lo); end
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, st);
    checks++; if (m.lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h want 80000000", m.lo); end
    checks++; if (m.hi !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h want 0", m.hi); end
  endtask

  task automatic test_reset_kill();
    int late;
    m.mdu_op = MULTU; m.A = 32'hFFFF_FFFF; m.B = 32'hFFFF_FFFF;
    @(negedge clk);
    m.mdu_op = NONE;
    repeat (2) @(negedge clk);
    checks++; if (m.busy !== 1'b1) begin errors++; $display("FAIL kill_busy_before: got %b want 1", m.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL kill_busy: got %b want 0", m.busy); end
    checks++; if (m.hi !== 32'h0) begin errors++; $display("FAIL kill_hi: got %h want 0", m.hi); end
    checks++; if (m.lo !== 32'h0) begin errors++; $display("FAIL kill_lo: got %h want 0", m.lo); end
    late = 0;
    repeat (12) begin
      @(negedge clk);
      if (m.busy !== 1'b0 || m.hi !== 32'h0 || m.lo !== 32'h0) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL kill_late_commit: got %0d bad cycles want 0", late); end
  endtask

  task automatic test_cancel();
    int cyc; logic st;
    run_op(MTLO, 32'h99, 32'h0, cyc, st);
    m.mdu_op = MULT; m.A = 32'd3; m.B = 32'd4; m.cancel = 1'b1; #1;
    checks++; if (m.stall_req !== 1'b0) begin errors++; $display("FAIL cancel_stall: got %b want 0", m.stall_req); end
    @(negedge clk);
    checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", m.busy); end
    m.mdu_op = MTHI; m.A = 32'h55;
    @(negedge clk);
    m.mdu_op = NONE; m.cancel = 1'b0;
    checks++; if (m.hi !== 32'h0) begin errors++; $display("FAIL cancel_hi: got %h want 0", m.hi); end
    checks++; if (m.lo !== 32'h99) begin errors++; $display("FAIL cancel_lo: got %h want 99", m.lo); end
    // cancel while already running does not stop the operation
    m.mdu_op = MULT; m.A = 32'd3; m.B = 32'd4;
    @(negedge clk);
    m.mdu_op = NONE; m.cancel = 1'b1;
    cyc = 0;
    while (m.busy === 1'b1 && cyc < 50) begin cyc++; @(negedge clk); end
    m.cancel = 1'b0;
    checks++; if (cyc != 5) begin errors++; $display("FAIL cancel_run_cycles: got %0d want 5", cyc); end
    checks++; if (m.lo !== 32'd12 || m.hi !== 32'h0) begin errors++; $display("FAIL cancel_run_result: got %h_%h want 00000000_0000000c", m.hi, m.lo); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic st;
    run_op(DIVU, 32'd100, 32'd7, cyc, st);
    checks++; if (m.lo !== 32'd14 || m.hi !== 32'd2) begin errors++; $display("FAIL b2b_divu: got %h_%h want 00000002_0000000e", m.hi, m.lo); end
    run_op(MULTU, 32'd6, 32'd7, cyc, st);
    checks++; if (cyc != 5) begin errors++; $display("FAIL b2b_multu_cycles: got %0d want 5", cyc); end
    checks++; if (m.lo !== 32'd42 || m.hi !== 32'h0) begin errors++; $display("FAIL b2b_multu: got %h_%h want 00000000_0000002a", m.hi, m.lo); end
  endtask

  task automatic test_fast();
    f.mdu_op = MULT; f.A = 32'hFFFF_FFFD; f.B = 32'd5;
    @(negedge clk);
    f.mdu_op = NONE;
    checks++; if (f.busy !== 1'b1) begin errors++; $display("FAIL fast_busy_pulse: got %b want 1", f.busy); end
    checks++; if (f.hi !== 32'h0) begin errors++; $display("FAIL fast_hi_early: got %h want 0", f.hi); end
    @(negedge clk);
    checks++; if (f.busy !== 1'b0) begin errors++; $display("FAIL fast_busy_end: got %b want 0", f.busy); end
    checks++; if (f.hi !== 32'hFFFF_FFFF || f.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL fast_mult: got %h_%h want ffffffff_fffffff1", f.hi, f.lo); end
    f.mdu_op = DIVU; f.A = 32'd7; f.B = 32'd2;
    @(negedge clk);
    f.mdu_op = NONE;
    @(negedge clk);
    checks++; if (f.busy !== 1'b0) begin errors++; $display("FAIL fast_div_busy: got %b want 0", f.busy); end
    checks++; if (f.hi !== 32'd1 || f.lo !== 32'd3) begin errors++; $display("FAIL fast_divu: got %h_%h want 00000001_00000003", f.hi, f.lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_div_corner();
    test_reset_kill();
    test_cancel();
    test_back_to_back();
    test_fast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
